// File: rtl/pc_unit.sv
// Program-counter unit for the LC3 datapath with an optional return-address stack.
// Define PC_RAS_EN to build the RAS, push/pop handling and the sticky overflow/underflow flags.
module pc_unit #(
   parameter int               WIDTH     = 16,
   parameter int               DEPTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ldPC,
   input  logic [1:0]       selPC,
   input  logic [WIDTH-1:0] eabOut,
   input  logic [WIDTH-1:0] Buss,
   input  logic             push,
   input  logic             pop,
   input  logic             clrFlags,
   output logic [WIDTH-1:0] PC,
   output logic             rasEmpty,
   output logic             rasFull,
   output logic             rasOvf,
   output logic             rasUnf
);

   logic [WIDTH-1:0] pc_q;
   logic [WIDTH-1:0] pc_d;
   logic [WIDTH-1:0] pc_inc;
   logic [WIDTH-1:0] ras_target;

   assign pc_inc = pc_q + WIDTH'(1);
   assign PC     = pc_q;

   always_comb begin
      pc_d = pc_q;
      if (ldPC) begin
         case (selPC)
            2'b00:   pc_d = pc_inc;
            2'b01:   pc_d = eabOut;
            2'b10:   pc_d = Buss;
            default: pc_d = ras_target;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q <= RESET_VEC;
      end else begin
         pc_q <= pc_d;
      end
   end

`ifdef PC_RAS_EN
   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] stack_q [DEPTH];
   logic [WIDTH-1:0] stack_d [DEPTH];
   logic [AW-1:0]    tp_q;
   logic [AW-1:0]    tp_d;
   logic [AW-1:0]    tp_next;
   logic [AW:0]      cnt_q;
   logic [AW:0]      cnt_d;
   logic             ovf_q;
   logic             ovf_d;
   logic             unf_q;
   logic             unf_d;
   logic             empty;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign empty      = (cnt_q == '0);
   assign full       = (cnt_q == FULL_CNT);
   assign tp_next    = tp_q + AW'(1);
   assign do_push    = ldPC & push;
   assign do_pop     = ldPC & pop & (selPC == 2'b11);
   // Any return-source load with an empty stack falls back to the reset vector.
   assign ras_target = empty ? RESET_VEC : stack_q[tp_q];

   always_comb begin
      stack_d = stack_q;
      tp_d    = tp_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q & ~clrFlags;
      unf_d   = unf_q & ~clrFlags;
      if (do_push && do_pop && !empty) begin
         stack_d[tp_q] = pc_inc;
      end else if (do_push) begin
         stack_d[tp_next] = pc_inc;
         tp_d             = tp_next;
         if (full) begin
            ovf_d = 1'b1;
         end else begin
            cnt_d = cnt_q + (AW+1)'(1);
         end
         // Swap on an empty stack: the pop underflows, the push still lands.
         if (do_pop) begin
            unf_d = 1'b1;
         end
      end else if (do_pop) begin
         if (empty) begin
            unf_d = 1'b1;
         end else begin
            tp_d  = tp_q - AW'(1);
            cnt_d = cnt_q - (AW+1)'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tp_q  <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         tp_q  <= tp_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   always_ff @(posedge clk) begin
      stack_q <= stack_d;
   end

   assign rasEmpty = empty;
   assign rasFull  = full;
   assign rasOvf   = ovf_q;
   assign rasUnf   = unf_q;
`else
   logic unused_inputs;

   assign unused_inputs = ^{push, pop, clrFlags};
   assign ras_target    = RESET_VEC;
   assign rasEmpty      = 1'b1;
   assign rasFull       = 1'b0;
   assign rasOvf        = 1'b0;
   assign rasUnf        = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Table-driven bench for pc_unit; expectations follow the PC_RAS_EN setting of the build.
module tb_pc_unit;

   typedef struct {
      logic        rst;
      logic        ld;
      logic [1:0]  sel;
      logic [15:0] eab;
      logic [15:0] bus;
      logic        psh;
      logic        pp;
      logic        clr;
      logic [15:0] pc;
      logic        emp;
      logic        full;
      logic        ovf;
      logic        unf;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        ldPC;
   logic [1:0]  selPC;
   logic [15:0] eabOut;
   logic [15:0] Buss;
   logic        push;
   logic        pop;
   logic        clrFlags;
   logic [15:0] PC;
   logic        rasEmpty;
   logic        rasFull;
   logic        rasOvf;
   logic        rasUnf;

   vec_t vecs[$];
   int   num_checks = 0;
   int   num_errors = 0;

   pc_unit #(.WIDTH(16), .DEPTH(8), .RESET_VEC(16'h0000)) dut (
      .clk      (clk),
      .reset    (reset),
      .ldPC     (ldPC),
      .selPC    (selPC),
      .eabOut   (eabOut),
      .Buss     (Buss),
      .push     (push),
      .pop      (pop),
      .clrFlags (clrFlags),
      .PC       (PC),
      .rasEmpty (rasEmpty),
      .rasFull  (rasFull),
      .rasOvf   (rasOvf),
      .rasUnf   (rasUnf)
   );

   always #5 clk = ~clk;

   task automatic add(input logic rst, input logic ld, input logic [1:0] sel,
                      input logic [15:0] eab, input logic [15:0] bus,
                      input logic psh, input logic pp, input logic clr,
                      input logic [15:0] pc, input logic emp, input logic full,
                      input logic ovf, input logic unf);
      vec_t v;
      v.rst = rst;  v.ld = ld;  v.sel = sel;  v.eab = eab;  v.bus = bus;
      v.psh = psh;  v.pp = pp;  v.clr = clr;
      v.pc = pc;    v.emp = emp; v.full = full; v.ovf = ovf; v.unf = unf;
      vecs.push_back(v);
   endtask

   task automatic applyStimulus(input vec_t v);
      reset    = v.rst;
      ldPC     = v.ld;
      selPC    = v.sel;
      eabOut   = v.eab;
      Buss     = v.bus;
      push     = v.psh;
      pop      = v.pp;
      clrFlags = v.clr;
   endtask

   task automatic checkBit(input int idx, input string what, input logic act, input logic exp);
      num_checks++;
      if (act !== exp) begin
         num_errors++;
         $display("[TB] FAIL vec%0d %s: got %b expected %b", idx, what, act, exp);
      end
   endtask

   task automatic checkOutput(input int idx, input vec_t v);
      num_checks++;
      if (PC !== v.pc) begin
         num_errors++;
         $display("[TB] FAIL vec%0d PC: got %h expected %h", idx, PC, v.pc);
      end
      checkBit(idx, "rasEmpty", rasEmpty, v.emp);
      checkBit(idx, "rasFull", rasFull, v.full);
      checkBit(idx, "rasOvf", rasOvf, v.ovf);
      checkBit(idx, "rasUnf", rasUnf, v.unf);
   endtask

   // Common prologue: reset, count 1..3, wrap through FFFF, hold for two cycles.
   task automatic addPrologue();
      add(1, 0, 2'd0, 16'h0, 16'h0,    0, 0, 0, 16'h0000, 1, 0, 0, 0);
      add(0, 1, 2'd0, 16'h0, 16'h0,    0, 0, 0, 16'h0001, 1, 0, 0, 0);
      add(0, 1, 2'd0, 16'h0, 16'h0,    0, 0, 0, 16'h0002, 1, 0, 0, 0);
      add(0, 1, 2'd0, 16'h0, 16'h0,    0, 0, 0, 16'h0003, 1, 0, 0, 0);
      add(0, 1, 2'd2, 16'h0, 16'hFFFF, 0, 0, 0, 16'hFFFF, 1, 0, 0, 0);
      add(0, 1, 2'd0, 16'h0, 16'h0,    0, 0, 0, 16'h0000, 1, 0, 0, 0);
      add(0, 0, 2'd2, 16'h0, 16'h1234, 0, 0, 0, 16'h0000, 1, 0, 0, 0);
      add(0, 0, 2'd1, 16'h5678, 16'h0, 0, 0, 0, 16'h0000, 1, 0, 0, 0);
   endtask

`ifdef PC_RAS_EN
   task automatic buildTable();
      addPrologue();
      // Call / return
      add(0, 1, 2'd2, 16'h0, 16'h0010,    0, 0, 0, 16'h0010, 1, 0, 0, 0);
      add(0, 1, 2'd1, 16'h0200, 16'h0,    1, 0, 0, 16'h0200, 0, 0, 0, 0);
      add(0, 1, 2'd1, 16'h0300, 16'h0,    1, 0, 0, 16'h0300, 0, 0, 0, 0);
      add(0, 1, 2'd3, 16'h0, 16'h0,       0, 1, 0, 16'h0201, 0, 0, 0, 0);
      add(0, 1, 2'd3, 16'h0, 16'h0,       0, 1, 0, 16'h0011, 1, 0, 0, 0);
      // Overflow: nine pushes returning 1..9, then eight pops
      add(0, 1, 2'd2, 16'h0, 16'h0000,    0, 0, 0, 16'h0000, 1, 0, 0, 0);
      for (int k = 1; k <= 9; k++)
         add(0, 1, 2'd2, 16'h0, 16'(k), 1, 0, 0, 16'(k), 0, (k >= 8), (k == 9), 0);
      for (int j = 0; j < 8; j++)
         add(0, 1, 2'd3, 16'h0, 16'h0, 0, 1, 0, 16'(9 - j), (j == 7), 0, 1, 0);
      // Underflow, clear, clear racing a new underflow
      add(0, 1, 2'd3, 16'h0, 16'h0,       0, 1, 0, 16'h0000, 1, 0, 1, 1);
      add(0, 0, 2'd0, 16'h0, 16'h0,       0, 0, 1, 16'h0000, 1, 0, 0, 0);
      add(0, 1, 2'd3, 16'h0, 16'h0,       0, 1, 1, 16'h0000, 1, 0, 0, 1);
      add(0, 0, 2'd0, 16'h0, 16'h0,       0, 0, 1, 16'h0000, 1, 0, 0, 0);
      // Swap with stack [0050] at PC 0070
      add(0, 1, 2'd2, 16'h0, 16'h004F,    0, 0, 0, 16'h004F, 1, 0, 0, 0);
      add(0, 1, 2'd2, 16'h0, 16'h0070,    1, 0, 0, 16'h0070, 0, 0, 0, 0);
      add(0, 1, 2'd3, 16'h0, 16'h0,       1, 1, 0, 16'h0050, 0, 0, 0, 0);
      add(0, 1, 2'd3, 16'h0, 16'h0,       0, 1, 0, 16'h0071, 1, 0, 0, 0);
      // Reset in the middle of a pop clears state and flags
      add(0, 1, 2'd3, 16'h0, 16'h0,       0, 1, 0, 16'h0000, 1, 0, 0, 1);
      add(0, 1, 2'd2, 16'h0, 16'h0123,    1, 0, 0, 16'h0123, 0, 0, 0, 1);
      add(1, 1, 2'd3, 16'h0, 16'h0,       0, 1, 0, 16'h0000, 1, 0, 0, 0);
      add(0, 1, 2'd3, 16'h0, 16'h0,       0, 1, 0, 16'h0000, 1, 0, 0, 1);
      // Unqualified requests
      add(0, 1, 2'd2, 16'h0, 16'h0400,    1, 0, 0, 16'h0400, 0, 0, 0, 1);
      add(0, 0, 2'd2, 16'h0, 16'h0999,   1, 0, 0, 16'h0400, 0, 0, 0, 1);
      add(0, 1, 2'd1, 16'h0500, 16'h0,    0, 1, 0, 16'h0500, 0, 0, 0, 1);
      add(0, 1, 2'd3, 16'h0, 16'h0,       0, 0, 0, 16'h0001, 0, 0, 0, 1);
      add(0, 1, 2'd3, 16'h0, 16'h0,       0, 1, 0, 16'h0001, 1, 0, 0, 1);
      // Swap on an empty stack still pushes
      add(0, 1, 2'd3, 16'h0, 16'h0,       1, 1, 0, 16'h0000, 0, 0, 0, 1);
      add(0, 1, 2'd3, 16'h0, 16'h0,       0, 1, 0, 16'h0002, 1, 0, 0, 1);
   endtask
`else
   task automatic buildTable();
      addPrologue();
      add(0, 1, 2'd2, 16'h0, 16'h0010,    0, 0, 0, 16'h0010, 1, 0, 0, 0);
      add(0, 1, 2'd1, 16'h0200, 16'h0,    1, 0, 0, 16'h0200, 1, 0, 0, 0);
      add(0, 1, 2'd3, 16'h0, 16'h0,       0, 1, 0, 16'h0000, 1, 0, 0, 0);
      add(0, 1, 2'd2, 16'h0, 16'h0070,    0, 0, 0, 16'h0070, 1, 0, 0, 0);
      add(0, 1, 2'd3, 16'h0, 16'h0,       1, 1, 0, 16'h0000, 1, 0, 0, 0);
      for (int k = 1; k <= 9; k++)
         add(0, 1, 2'd2, 16'h0, 16'(k), 1, 0, 0, 16'(k), 1, 0, 0, 0);
      add(0, 1, 2'd3, 16'h0, 16'h0,       0, 0, 1, 16'h0000, 1, 0, 0, 0);
      add(0, 1, 2'd3, 16'h0, 16'h0,       0, 1, 0, 16'h0000, 1, 0, 0, 0);
      add(1, 1, 2'd0, 16'h0, 16'h0,       0, 0, 0, 16'h0000, 1, 0, 0, 0);
      add(0, 1, 2'd0, 16'h0, 16'h0,       0, 0, 0, 16'h0001, 1, 0, 0, 0);
   endtask
`endif

   initial begin
      vec_t v;
      reset    = 1'b1;
      ldPC     = 1'b0;
      selPC    = 2'b00;
      eabOut   = '0;
      Buss     = '0;
      push     = 1'b0;
      pop      = 1'b0;
      clrFlags = 1'b0;
      buildTable();
      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         applyStimulus(v);
         @(posedge clk);
         #1;
         checkOutput(i, v);
      end
      $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
      $finish;
   end

endmodule
